uart_tx_sequencer: RTL and testbench
====================================

# uart_tx_sequencer

APB master that drives the APB UART wrapper's register map to send bytes on behalf of several on-chip requesters. After reset it programs the baud divisor and pulses the TX/RX resets. It then arbitrates round-robin between requesters and runs the per-byte sequence: write TX_DATA, set tx_en, poll STATS for tx_done, clear CTRL. It sits between client logic and the UART wrapper's APB slave port, and is the only APB master on that port.

## Interface
- NREQ, 2, number of requesters (1..8)
- PADDR_WIDTH, 32, APB address width
- PDATA_WIDTH, 32, APB data width
- BAUDIV_INIT, 32'd868, value written to BAUDIV (0x4) during init
- TX_DONE_BIT, 0, bit index of tx_done in STATS (0x1)
- POLL_LIMIT, 65535, max STATS reads per byte before timeout

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset; synchronous, active-high
- req  in  NREQ  per-requester send request (level)
- req_data  in  8*NREQ  byte for requester i in [8i+7:8i]
- ack  out  NREQ  one-cycle done pulse to the granted requester
- ack_err  out  1  valid with ack; 1 = byte failed (PSLVERR or timeout)
- busy  out  1  high from init start until IDLE, and during every byte sequence
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls
- PADDR  out  PADDR_WIDTH  APB address
- PWDATA  out  PDATA_WIDTH  APB write data
- PRDATA  in  PDATA_WIDTH  APB read data
- PREADY, PSLVERR  in  1 each  APB slave response

## Operation
- Register map: CTRL=0x0, STATS=0x1, TX_DATA=0x2, BAUDIV=0x4.
- CTRL bits: [0] tx_en, [1] rx_en, [2] tx_rst, [3] rx_rst. rx_en is always written 0.
- Main FSM: INIT_BAUD -> INIT_RST -> INIT_CLR -> IDLE -> WR_DATA -> WR_EN -> POLL -> CLR -> IDLE.
- Init writes, in order:
  - BAUDIV <= BAUDIV_INIT
  - CTRL <= 0xC
  - CTRL <= 0x0
- IDLE:
  - If any req is high, pick the requester per the round-robin rule below.
  - Register its index and byte, then go to WR_DATA.
- Round robin:
  - Search starts at (last granted + 1) mod NREQ.
  - After reset the pointer is NREQ-1, so requester 0 wins first.
- WR_DATA writes TX_DATA <= {24'b0, byte}. WR_EN writes CTRL <= 0x1.
- POLL:
  - Read STATS repeatedly.
  - On PRDATA[TX_DONE_BIT]=1, go to CLR.
  - Every read increments poll_cnt (cleared on entry to POLL).
- CLR:
  - Normal path writes CTRL <= 0x0.
  - Error path writes CTRL <= 0x4, then CTRL <= 0x0.
- After CLR completes: pulse ack[idx] for one cycle, with ack_err set if this is the error path. Return to IDLE.
- PSLVERR=1 on any completing transfer in WR_DATA, WR_EN or POLL: abandon the sequence and take the error path.
- PSLVERR during init or CLR: ignored.
- A requester must hold req and req_data stable until ack. A req still high in the cycle after ack counts as a new request.
- A req dropped before grant is simply not serviced.
- req_data is sampled only at grant.

## Timing
- Reset values:
  - Outputs: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, ack=0, ack_err=0.
  - busy=1, because the FSM enters INIT_BAUD.
  - RR pointer NREQ-1, poll_cnt 0.
- Every transfer uses SETUP (PSEL=1, PENABLE=0), then ACCESS (PSEL=1, PENABLE=1).
  - ACCESS is held until PREADY=1.
  - Then one IDLE cycle (PSEL=0) before the next transfer.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle.
- STATS is sampled on the PCLK edge where PENABLE & PREADY.
- Latency from req rising in IDLE to PSEL=1 for WR_DATA is 2 cycles: grant registers on the first edge, SETUP drives on the second.
- Zero-wait slave:
  - Minimum length of one byte from SETUP of WR_DATA to ack is 4 transfers × 3 cycles + 1.
  - Each extra poll adds 3 cycles.
- ack fires on the edge after the IDLE cycle of the last CLR transfer. busy drops in the same cycle.
- PRESET mid-sequence:
  - Returns all outputs to reset values on the next edge, with no ack.
  - The FSM restarts init.
- Simultaneous req on all lines: exactly one grant per sequence, rotated.

## Configuration
- UART_SEQ_TIMEOUT_EN defined:
  - In POLL, if poll_cnt reaches POLL_LIMIT without tx_done, take the error path (tx_rst pulse, ack_err=1).
- Not defined:
  - POLL reads until tx_done or PSLVERR. The poll_cnt counter and comparator are absent.
  - POLL_LIMIT is unused.

## Test plan
- Init after reset, zero-wait slave -> exactly three writes: (0x4, 868), (0x0, 0xC), (0x0, 0x0). busy falls after the third.
- req[0]=1, byte 0x55, slave reports tx_done on the 3rd STATS read:
  - Writes (0x2, 0x55), then (0x0, 0x1).
  - Three reads of 0x1.
  - Write (0x0, 0x0).
  - ack[0] pulses once, ack_err=0.
- req[0] and req[1] high together with 0xA1 and 0xB2, held after ack:
  - Grant order 0, 1, 0, 1.
  - TX_DATA writes alternate 0xA1, 0xB2.
- PREADY low for 5 cycles on the WR_EN access -> PSEL and PENABLE stay high for 6 ACCESS cycles with PADDR=0x0 and PWDATA=0x1 constant.
- PSLVERR=1 on the WR_DATA transfer:
  - Next writes are CTRL 0x4, then 0x0.
  - ack pulses with ack_err=1.
  - No STATS reads occur.
- With UART_SEQ_TIMEOUT_EN and POLL_LIMIT=4, tx_done never set -> exactly 4 STATS reads, then CTRL 0x4, CTRL 0x0, ack_err=1. Without the macro, reads continue indefinitely.

Source files
------------

// File: rtl/uart_tx_sequencer_if.sv
// uart_tx_sequencer_if: APB bus between the sequencer (master) and the UART wrapper (slave).
interface uart_tx_sequencer_if #(
    parameter int PADDR_WIDTH = 32,
    parameter int PDATA_WIDTH = 32
);
    logic                   PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [PADDR_WIDTH-1:0] PADDR;
    logic [PDATA_WIDTH-1:0] PWDATA;
    logic [PDATA_WIDTH-1:0] PRDATA;
    logic                   PREADY;
    logic                   PSLVERR;
    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );
    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: APB master that initialises the UART wrapper and sends requester bytes round-robin.
// Optional UART_SEQ_TIMEOUT_EN bounds POLL to POLL_LIMIT STATS reads before taking the error path.
module uart_tx_sequencer #(
    parameter int          NREQ        = 2,
    parameter int          PADDR_WIDTH = 32,
    parameter int          PDATA_WIDTH = 32,
    parameter logic [31:0] BAUDIV_INIT = 32'd868,
    parameter int          TX_DONE_BIT = 0,
    parameter int          POLL_LIMIT  = 65535
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [NREQ-1:0]        req,
    input  logic [8*NREQ-1:0]      req_data,
    output logic [NREQ-1:0]        ack,
    output logic                   ack_err,
    output logic                   busy,
    uart_tx_sequencer_if.master    apb
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic [3:0] {
        S_INIT_BAUD, S_INIT_RST, S_INIT_CLR, S_IDLE, S_WR_DATA,
        S_WR_EN, S_POLL, S_ERR_RST, S_CLR, S_FIN
    } state_t;
    typedef enum logic [1:0] {P_GAP, P_SETUP, P_ACCESS} phase_t;
    state_t                 r_state;
    phase_t                 r_ph;
    logic [IW-1:0]          r_idx;
    logic [IW-1:0]          r_ptr;
    logic [7:0]             r_byte;
    logic                   r_err;
    logic                   r_seq;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [PADDR_WIDTH-1:0] r_paddr;
    logic [PDATA_WIDTH-1:0] r_pwdata;
    logic [NREQ-1:0]        r_ack;
    logic                   r_ack_err;
    logic                   r_busy;
    logic [IW-1:0]          w_gnt;
    logic [PADDR_WIDTH-1:0] w_addr;
    logic [PDATA_WIDTH-1:0] w_wdata;
    logic                   w_fail;
    logic                   w_tmo;
    state_t                 w_next;
`ifdef UART_SEQ_TIMEOUT_EN
    localparam int PCW = $clog2(POLL_LIMIT + 1);
    logic [PCW-1:0]         r_poll_cnt;
`endif
    assign apb.PSEL    = r_psel;
    assign apb.PENABLE = r_penable;
    assign apb.PWRITE  = r_pwrite;
    assign apb.PADDR   = r_paddr;
    assign apb.PWDATA  = r_pwdata;
    assign ack         = r_ack;
    assign ack_err     = r_ack_err;
    assign busy        = r_busy;
    // Scan downward so the nearest requester after the pointer wins.
    always_comb begin
        w_gnt = r_ptr;
        for (int k = NREQ; k >= 1; k--)
            if (req[(int'(r_ptr) + k) % NREQ]) w_gnt = IW'((int'(r_ptr) + k) % NREQ);
    end
    always_comb begin
        w_addr  = r_state == S_INIT_BAUD ? PADDR_WIDTH'(4) :
                  r_state == S_WR_DATA   ? PADDR_WIDTH'(2) :
                  r_state == S_POLL      ? PADDR_WIDTH'(1) : '0;
        w_wdata = r_state == S_INIT_BAUD ? PDATA_WIDTH'(BAUDIV_INIT) :
                  r_state == S_INIT_RST  ? PDATA_WIDTH'(4'hC) :
                  r_state == S_WR_DATA   ? PDATA_WIDTH'(r_byte) :
                  r_state == S_WR_EN     ? PDATA_WIDTH'(1) :
                  r_state == S_ERR_RST   ? PDATA_WIDTH'(4) : '0;
        w_fail  = apb.PSLVERR && (r_state inside {S_WR_DATA, S_WR_EN, S_POLL});
`ifdef UART_SEQ_TIMEOUT_EN
        w_tmo   = r_state == S_POLL && r_poll_cnt == PCW'(POLL_LIMIT - 1) && !apb.PRDATA[TX_DONE_BIT];
`else
        w_tmo   = 1'b0;
`endif
        w_next  = (w_fail || w_tmo)      ? S_ERR_RST :
                  r_state == S_INIT_BAUD ? S_INIT_RST :
                  r_state == S_INIT_RST  ? S_INIT_CLR :
                  r_state == S_WR_DATA   ? S_WR_EN :
                  r_state == S_WR_EN     ? S_POLL :
                  r_state == S_POLL      ? (apb.PRDATA[TX_DONE_BIT] ? S_CLR : S_POLL) :
                  r_state == S_ERR_RST   ? S_CLR : S_FIN;
    end
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= S_INIT_BAUD;
            r_ph      <= P_GAP;
            r_idx     <= '0;
            r_ptr     <= IW'(NREQ - 1);
            r_byte    <= '0;
            r_err     <= 1'b0;
            r_seq     <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_ack     <= '0;
            r_ack_err <= 1'b0;
            r_busy    <= 1'b1;
`ifdef UART_SEQ_TIMEOUT_EN
            r_poll_cnt <= '0;
`endif
        end else begin
            r_ack     <= '0;
            r_ack_err <= 1'b0;
            case (r_state)
                // Hold off during the ack cycle so a requester gets one cycle to drop req.
                S_IDLE: if (|req && !(|r_ack)) begin
                    r_idx   <= w_gnt;
                    r_ptr   <= w_gnt;
                    r_byte  <= req_data[8*w_gnt +: 8];
                    r_err   <= 1'b0;
                    r_seq   <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= S_WR_DATA;
                end
                S_FIN: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_ack     <= r_seq ? NREQ'(1) << r_idx : '0;
                    r_ack_err <= r_seq && r_err;
                    r_seq     <= 1'b0;
                end
                default: case (r_ph)
                    P_GAP: begin
                        r_psel   <= 1'b1;
                        r_paddr  <= w_addr;
                        r_pwdata <= w_wdata;
                        r_pwrite <= r_state != S_POLL;
                        r_ph     <= P_SETUP;
                    end
                    P_SETUP: begin
                        r_penable <= 1'b1;
                        r_ph      <= P_ACCESS;
                    end
                    default: if (apb.PREADY) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_ph      <= P_GAP;
                        r_state   <= w_next;
                        r_err     <= r_err || w_next == S_ERR_RST;
`ifdef UART_SEQ_TIMEOUT_EN
                        r_poll_cnt <= r_state == S_POLL ? r_poll_cnt + PCW'(1) : '0;
`endif
                    end
                endcase
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: randomized bench with an APB slave model and a transaction-list reference model.
module tb_uart_tx_sequencer;
    localparam int NREQ = 3;
    localparam int DW   = 8 * NREQ;
    localparam int TXB  = 0;
    localparam int PL   = 4;
    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] data;
        int          acc;
        bit          stable;
    } rec_t;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [DW-1:0]   req_data = '0;
    logic [NREQ-1:0] ack;
    logic            ack_err;
    logic            busy;
    always #5 clk = ~clk;
    uart_tx_sequencer_if #(.PADDR_WIDTH(32), .PDATA_WIDTH(32)) apb ();
    uart_tx_sequencer #(.NREQ(NREQ), .TX_DONE_BIT(TXB), .POLL_LIMIT(PL)) dut (
        .PCLK(clk), .PRESET(rst), .req(req), .req_data(req_data),
        .ack(ack), .ack_err(ack_err), .busy(busy), .apb(apb.master)
    );
    rec_t recs[$];
    int   err_at = 0, done_at = 1000, wait_xfer = 0, wait_n = 0, arm_id = 0;
    bit   rand_wait = 1'b0;
    int   seen_arm = 0, xfer_n = 0, stat_n = 0, cur_wait = 0, wcnt = 0;
    rec_t cur;
    int   n_cmp = 0, n_fail = 0, m_ptr = NREQ - 1, rec_base = 0;
    // APB slave model: decides PREADY/PSLVERR/PRDATA for the coming edge and logs completed transfers.
    always @(negedge clk) begin
        if (seen_arm != arm_id) begin
            seen_arm = arm_id;
            xfer_n = 0;
            stat_n = 0;
        end
        apb.PREADY = 1'b0;
        apb.PSLVERR = 1'b0;
        if (apb.PSEL && !apb.PENABLE) begin
            cur_wait = rand_wait ? int'($urandom_range(0, 3)) : (xfer_n + 1 == wait_xfer ? wait_n : 0);
            wcnt = 0;
            cur.w = apb.PWRITE;
            cur.addr = apb.PADDR;
            cur.data = apb.PWDATA;
            cur.acc = 0;
            cur.stable = 1'b1;
        end else if (apb.PSEL && apb.PENABLE) begin
            cur.acc++;
            if (apb.PADDR !== cur.addr || apb.PWDATA !== cur.data || apb.PWRITE !== cur.w) cur.stable = 1'b0;
            if (wcnt < cur_wait) wcnt++;
            else begin
                xfer_n++;
                apb.PREADY = 1'b1;
                apb.PSLVERR = (xfer_n == err_at);
                if (!cur.w) begin
                    stat_n++;
                    apb.PRDATA = $urandom;
                    apb.PRDATA[TXB] = (stat_n >= done_at);
                end
                recs.push_back(cur);
            end
        end
    end
    function automatic string obs_list(int base);
        string s = "";
        for (int i = base; i < recs.size(); i++)
            s = {s, recs[i].w ? $sformatf("W%0h:%0h ", recs[i].addr, recs[i].data) : $sformatf("R%0h ", recs[i].addr)};
        return s;
    endfunction
    // Reference: the APB transactions one byte must produce, given reads-until-done and error position.
    function automatic string exp_list(logic [7:0] b, int k, int e);
        string s = $sformatf("W2:%0h ", b);
        if (e == 1) return {s, "W0:4 W0:0 "};
        s = {s, "W0:1 "};
        if (e == 2) return {s, "W0:4 W0:0 "};
        if (e == 3) return {s, "R1 W0:4 W0:0 "};
        repeat (k) s = {s, "R1 "};
        return {s, "W0:0 "};
    endfunction
    function automatic int rr_pick(int ptr, logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction
    task automatic run_byte(input logic [NREQ-1:0] m, input logic [DW-1:0] d, input int k, input int e,
                            output bit got, output int idx, output bit err, output int lat, output int span);
        int cyc = 0;
        done_at = k;
        err_at = e;
        arm_id++;
        rec_base = recs.size();
        req_data = d;
        req = m;
        got = 1'b0; idx = -1; err = 1'b0; lat = -1;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (apb.PSEL && lat < 0) lat = cyc;
            if (|ack) begin
                got = 1'b1;
                err = ack_err;
                for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
            end
        end
        span = cyc - lat + 1;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({apb.PSEL, apb.PENABLE, apb.PWRITE} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {apb.PSEL, apb.PENABLE, apb.PWRITE}); end
        n_cmp++; if (apb.PADDR !== 32'h0 || apb.PWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_bus: got addr %h data %h expected 0", apb.PADDR, apb.PWDATA); end
        n_cmp++; if (ack !== '0 || ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b/%b expected 0/0", ack, ack_err); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    endtask
    task automatic test_init;
        int cyc = 0;
        bit seen_ack = 1'b0;
        rec_base = recs.size();
        rst = 1'b0;
        while (busy !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (|ack) seen_ack = 1'b1;
        end
        n_cmp++; if (obs_list(rec_base) != "W4:364 W0:c W0:0 ") begin n_fail++; $display("FAIL init_seq: got '%s' expected 'W4:364 W0:c W0:0 '", obs_list(rec_base)); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy: got %b expected 0 within 200 cycles", busy); end
        n_cmp++; if (seen_ack) begin n_fail++; $display("FAIL init_ack: got ack during init expected none"); end
    endtask
    task automatic test_single;
        bit got, err;
        int idx, lat, span;
        int ei = rr_pick(m_ptr, 3'b001);
        run_byte(3'b001, 24'h000055, 3, 0, got, idx, err, lat, span);
        m_ptr = ei;
        n_cmp++; if (!got || idx != ei) begin n_fail++; $display("FAIL single_ack: got idx %0d (acked %b) expected %0d", idx, got, ei); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", err); end
        n_cmp++; if (obs_list(rec_base) != exp_list(8'h55, 3, 0)) begin n_fail++; $display("FAIL single_seq: got '%s' expected '%s'", obs_list(rec_base), exp_list(8'h55, 3, 0)); end
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", lat); end
        n_cmp++; if (span != 3 * (3 + 3) + 1) begin n_fail++; $display("FAIL single_span: got %0d expected %0d", span, 3 * (3 + 3) + 1); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0 at ack", busy); end
        req = '0;
        @(negedge clk);
        n_cmp++; if (ack !== '0) begin n_fail++; $display("FAIL single_pulse: got %b expected 0 one cycle after ack", ack); end
    endtask
    task automatic test_reset_mid;
        int cyc = 0;
        bit seen_ack = 1'b0;
        done_at = 1000;
        err_at = 0;
        arm_id++;
        req_data = DW'($urandom);
        req = 3'b010;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({apb.PSEL, apb.PENABLE, apb.PWRITE} !== 3'b000 || apb.PADDR !== 32'h0 || apb.PWDATA !== 32'h0) begin n_fail++; $display("FAIL midreset_bus: got %b addr %h data %h expected all 0", {apb.PSEL, apb.PENABLE, apb.PWRITE}, apb.PADDR, apb.PWDATA); end
        n_cmp++; if (busy !== 1'b1 || ack !== '0) begin n_fail++; $display("FAIL midreset_out: got busy %b ack %b expected 1/0", busy, ack); end
        req = '0;
        rst = 1'b0;
        m_ptr = NREQ - 1;
        rec_base = recs.size();
        while (busy !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (|ack) seen_ack = 1'b1;
        end
        n_cmp++; if (obs_list(rec_base) != "W4:364 W0:c W0:0 " || seen_ack) begin n_fail++; $display("FAIL midreset_reinit: got '%s' ack_seen %b expected 'W4:364 W0:c W0:0 ' no ack", obs_list(rec_base), seen_ack); end
    endtask
    task automatic test_round_robin;
        int exp_seq[4] = '{0, 1, 0, 1};
        logic [DW-1:0] d = 24'h00B2A1;
        for (int i = 0; i < 4; i++) begin
            bit got, err;
            int idx, lat, span;
            int k = int'($urandom_range(1, 3));
            string ex = exp_list(i % 2 == 0 ? 8'hA1 : 8'hB2, k, 0);
            run_byte(3'b011, d, k, 0, got, idx, err, lat, span);
            m_ptr = exp_seq[i];
            n_cmp++; if (!got || idx != exp_seq[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, idx, exp_seq[i]); end
            n_cmp++; if (obs_list(rec_base) != ex || err !== 1'b0) begin n_fail++; $display("FAIL rr_seq[%0d]: got '%s' err %b expected '%s' err 0", i, obs_list(rec_base), err, ex); end
        end
    endtask
    task automatic test_wait;
        bit got, err;
        int idx, lat, span;
        logic [DW-1:0] d = DW'($urandom);
        int ei = rr_pick(m_ptr, 3'b100);
        wait_xfer = 2;
        wait_n = 5;
        run_byte(3'b100, d, 1, 0, got, idx, err, lat, span);
        m_ptr = ei;
        wait_xfer = 0;
        n_cmp++; if (!got || idx != ei || obs_list(rec_base) != exp_list(d[8*ei +: 8], 1, 0)) begin n_fail++; $display("FAIL wait_seq: got idx %0d '%s' expected idx %0d '%s'", idx, obs_list(rec_base), ei, exp_list(d[8*ei +: 8], 1, 0)); end
        n_cmp++; if (recs.size() < rec_base + 2 || recs[rec_base + 1].acc != 6) begin n_fail++; $display("FAIL wait_access: got %0d ACCESS cycles expected 6", recs.size() < rec_base + 2 ? -1 : recs[rec_base + 1].acc); end
        n_cmp++; if (recs.size() < rec_base + 2 || !recs[rec_base + 1].stable) begin n_fail++; $display("FAIL wait_stable: got unstable PADDR/PWDATA/PWRITE expected stable"); end
    endtask
    task automatic test_pslverr;
        for (int e = 1; e <= 3; e += 2) begin
            bit got, err;
            int idx, lat, span;
            logic [DW-1:0] d = DW'($urandom);
            int ei = rr_pick(m_ptr, 3'b001);
            run_byte(3'b001, d, 2, e, got, idx, err, lat, span);
            m_ptr = ei;
            n_cmp++; if (!got || idx != ei || err !== 1'b1) begin n_fail++; $display("FAIL slverr_ack[%0d]: got idx %0d err %b expected idx %0d err 1", e, idx, err, ei); end
            n_cmp++; if (obs_list(rec_base) != exp_list(d[7:0], 2, e)) begin n_fail++; $display("FAIL slverr_seq[%0d]: got '%s' expected '%s'", e, obs_list(rec_base), exp_list(d[7:0], 2, e)); end
        end
        req = '0;
    endtask
    task automatic test_timeout;
        bit got, err;
        int idx, lat, span;
        logic [DW-1:0] d = DW'($urandom);
        string ex;
        int ei = rr_pick(m_ptr, 3'b010);
`ifdef UART_SEQ_TIMEOUT_EN
        ex = $sformatf("W2:%0h W0:1 R1 R1 R1 R1 W0:4 W0:0 ", d[15:8]);
        run_byte(3'b010, d, 1000, 0, got, idx, err, lat, span);
        n_cmp++; if (!got || err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got ack %b err %b expected 1/1", got, err); end
`else
        ex = exp_list(d[15:8], 9, 0);
        run_byte(3'b010, d, 9, 0, got, idx, err, lat, span);
        n_cmp++; if (!got || err !== 1'b0) begin n_fail++; $display("FAIL notimeout_err: got ack %b err %b expected 1/0", got, err); end
`endif
        m_ptr = ei;
        n_cmp++; if (obs_list(rec_base) != ex || idx != ei) begin n_fail++; $display("FAIL timeout_seq: got idx %0d '%s' expected idx %0d '%s'", idx, obs_list(rec_base), ei, ex); end
        req = '0;
    endtask
    task automatic test_random;
        rand_wait = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bit got, err;
            int idx, lat, span;
            logic [NREQ-1:0] m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            logic [DW-1:0] d = DW'($urandom);
            int k = int'($urandom_range(1, 4));
            int e = $urandom_range(0, 9) < 3 ? int'($urandom_range(1, 3)) : 0;
            int ei = rr_pick(m_ptr, m);
            string ex = exp_list(d[8*ei +: 8], k, e);
            run_byte(m, d, k, e, got, idx, err, lat, span);
            m_ptr = ei;
            n_cmp++; if (!got || idx != ei || err !== (e != 0)) begin n_fail++; $display("FAIL rand_ack[%0d]: got idx %0d err %b expected idx %0d err %b", i, idx, err, ei, e != 0); end
            n_cmp++; if (obs_list(rec_base) != ex) begin n_fail++; $display("FAIL rand_seq[%0d]: got '%s' expected '%s'", i, obs_list(rec_base), ex); end
        end
        rand_wait = 1'b0;
        req = '0;
    endtask
    initial begin
        test_reset;
        test_init;
        test_single;
        test_reset_mid;
        test_round_robin;
        test_wait;
        test_pslverr;
        test_timeout;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
